// File: rtl/minsoc_wb_ram.sv
// Wishbone B3 on-chip RAM built from 2^(ADR_WIDTH-BANK_AW) banks with byte-lane writes.
// Latency: registered ack/err one cycle after the request; with MINSOC_RAM_BURST_EN, burst beats follow with no wait states.
// Backpressure: classic accesses leave one idle cycle after each ack; a burst stops as soon as cyc/stb drops.
module minsoc_wb_ram #(
   parameter int ADR_WIDTH = 13,
   parameter int BANK_AW   = 11,
   parameter int DW        = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [DW-1:0]     wb_dat_i,
   output logic [DW-1:0]     wb_dat_o,
   input  logic [DW/8-1:0]   wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic              wb_ack_o,
   output logic              wb_err_o
);

   localparam int SW    = DW / 8;
   localparam int NBANK = 1 << (ADR_WIDTH - BANK_AW);
   localparam int BSW   = (ADR_WIDTH > BANK_AW) ? (ADR_WIDTH - BANK_AW) : 1;
   localparam int DEPTH = 1 << BANK_AW;

   typedef logic [ADR_WIDTH-1:0] wadr_t;

`ifdef MINSOC_RAM_BURST_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLASSIC = 2'd1,
      ST_ERR     = 2'd2,
      ST_BURST   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLASSIC = 2'd1,
      ST_ERR     = 2'd2
   } state_t;
`endif

   function automatic logic [BSW-1:0] bank_of(input wadr_t a);
      bank_of = BSW'(a >> BANK_AW);
   endfunction

   function automatic logic [BANK_AW-1:0] off_of(input wadr_t a);
      off_of = a[BANK_AW-1:0];
   endfunction

   state_t          state_q, state_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic            we_q;
   wadr_t           cur_adr;
   wadr_t           req_adr;
   wadr_t           rd_adr;
   logic            req;
   logic            oor;
   logic            ld_adr;
   logic            wr_en;
   logic [BSW-1:0]  wr_bank, rd_bank, rd_bank_q;
   logic [BANK_AW-1:0] wr_off, rd_off;
   logic [NBANK-1:0][DW-1:0] bank_rd;

`ifdef MINSOC_RAM_BURST_EN
   logic [1:0]      bte_q;
   logic            adv;
   wadr_t           nxt_adr;
   wadr_t           wrap_mask;
   wadr_t           inc_adr;
`endif

   assign req     = wb_cyc_i & wb_stb_i;
   assign req_adr = wb_adr_i[ADR_WIDTH+1:2];

   // Any set bit between the top word-address bit and bit 23 flags an out-of-range access.
   always_comb begin
      oor = 1'b0;
      for (int i = ADR_WIDTH + 2; i < 24; i++) begin
         oor = oor | wb_adr_i[i];
      end
   end

`ifdef MINSOC_RAM_BURST_EN
   // Next beat address: linear wraps the whole space, wrap-N only steps the low bits.
   always_comb begin
      wrap_mask = '1;
      case (bte_q)
         2'b01:   wrap_mask = wadr_t'(3);
         2'b10:   wrap_mask = wadr_t'(7);
         2'b11:   wrap_mask = wadr_t'(15);
         default: wrap_mask = '1;
      endcase
      inc_adr = cur_adr + wadr_t'(1);
      nxt_adr = (cur_adr & ~wrap_mask) | (inc_adr & wrap_mask);
   end
`endif

   // Next-state and registered-output decode.
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      ld_adr  = 1'b0;
`ifdef MINSOC_RAM_BURST_EN
      adv     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (oor) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  ld_adr = 1'b1;
                  ack_d  = 1'b1;
`ifdef MINSOC_RAM_BURST_EN
                  if (wb_cti_i == 3'b010) state_d = ST_BURST;
                  else                    state_d = ST_CLASSIC;
`else
                  state_d = ST_CLASSIC;
`endif
               end
            end
         end
`ifdef MINSOC_RAM_BURST_EN
         ST_BURST: begin
            // A completing beat tagged end-of-burst, or a dropped strobe, ends the burst.
            if (req && (wb_cti_i != 3'b111)) begin
               ack_d = 1'b1;
               adv   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state, acknowledges and the captured beat-0 attributes.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         cur_adr <= '0;
`ifdef MINSOC_RAM_BURST_EN
         bte_q   <= 2'b00;
`endif
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         if (ld_adr) begin
            cur_adr <= req_adr;
            we_q    <= wb_we_i;
`ifdef MINSOC_RAM_BURST_EN
            bte_q   <= wb_bte_i;
         end else if (adv) begin
            cur_adr <= nxt_adr;
`endif
         end
      end
   end

   // Read address: the incoming request in IDLE, the following beat when a burst beat completes.
   always_comb begin
      rd_adr = cur_adr;
      if (state_q == ST_IDLE) begin
         rd_adr = req_adr;
`ifdef MINSOC_RAM_BURST_EN
      end else if (adv) begin
         rd_adr = nxt_adr;
`endif
      end
   end

   // A beat commits only when its ack is seen with cyc/stb still high; reset discards it.
   assign wr_en   = ack_q & req & we_q & ~wb_rst_i;
   assign wr_bank = bank_of(cur_adr);
   assign wr_off  = off_of(cur_adr);
   assign rd_bank = bank_of(rd_adr);
   assign rd_off  = off_of(rd_adr);

   generate
      for (genvar b = 0; b < NBANK; b++) begin : g_bank
         logic [DW-1:0] mem [DEPTH];
         logic [DW-1:0] q;

         // Byte-lane write port and synchronous read port of one bank.
         always_ff @(posedge wb_clk_i) begin
            if (wr_en && (wr_bank == BSW'(b))) begin
               for (int n = 0; n < SW; n++) begin
                  if (wb_sel_i[n]) mem[wr_off][8*n +: 8] <= wb_dat_i[8*n +: 8];
               end
            end
            q <= mem[rd_off];
         end

         assign bank_rd[b] = q;
      end
   endgenerate

   // Remember which bank was read so the output mux lines up with the bank data.
   always_ff @(posedge wb_clk_i) begin
      rd_bank_q <= rd_bank;
   end

   assign wb_dat_o = bank_rd[rd_bank_q];
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;

   logic unused_bits;
`ifdef MINSOC_RAM_BURST_EN
   assign unused_bits = ^{wb_adr_i[31:24], wb_adr_i[1:0]};
`else
   assign unused_bits = ^{wb_adr_i[31:24], wb_adr_i[1:0], wb_cti_i, wb_bte_i};
`endif

endmodule

// File: tb/tb_minsoc_wb_ram.sv
// Directed checks of minsoc_wb_ram: classic access, byte lanes, range error, aborts and reset.
// Burst sequences are exercised when MINSOC_RAM_BURST_EN is defined.
// Outputs are sampled 1 time unit after each rising edge.
module tb_minsoc_wb_ram;

   logic        clk;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_arr [16];
   logic [31:0] wd_arr  [16];

   minsoc_wb_ram dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dat_w),
      .wb_dat_o (dat_r),
      .wb_sel_i (sel),
      .wb_we_i  (we),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_cti_i (cti),
      .wb_bte_i (bte),
      .wb_ack_o (ack),
      .wb_err_o (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      cti = 3'b000; bte = 2'b00; adr = 32'h0; dat_w = 32'h0;
   endtask

   // Classic access: request sampled at the next edge, ack checked in the cycle after, then dropped.
   task automatic classic(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input logic [31:0] exp_rd, input logic chk_rd,
                          input string tag);
      cyc = 1'b1; stb = 1'b1; adr = a; dat_w = d; sel = s; we = w; cti = 3'b000; bte = 2'b00;
      @(posedge clk); #1;
      chk({tag, "_ack"}, ack, 1);
      chk({tag, "_err"}, err, 0);
      if (chk_rd) chk({tag, "_dat"}, dat_r, exp_rd);
      @(posedge clk); #1;
      bus_idle();
      chk({tag, "_ackoff"}, ack, 0);
   endtask

   task automatic oor_access(input logic [31:0] a, input logic w, input string tag);
      cyc = 1'b1; stb = 1'b1; adr = a; dat_w = 32'h0; sel = 4'hF; we = w;
      @(posedge clk); #1;
      chk({tag, "_err"}, err, 1);
      chk({tag, "_ack"}, ack, 0);
      @(posedge clk); #1;
      bus_idle();
      chk({tag, "_erroff"}, err, 0);
      chk({tag, "_ack2"}, ack, 0);
   endtask

`ifdef MINSOC_RAM_BURST_EN
   // Burst of n beats (n >= 2); expected read data in exp_arr, write data in wd_arr.
   task automatic burst(input logic [31:0] a, input logic w, input logic [1:0] b,
                        input int n, input string tag);
      cyc = 1'b1; stb = 1'b1; adr = a; we = w; bte = b; cti = 3'b010; sel = 4'hF;
      dat_w = wd_arr[0];
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         cti   = (k == n - 1) ? 3'b111 : 3'b010;
         dat_w = wd_arr[k];
         adr   = 32'h0000_0FF0;
         chk($sformatf("%s_ack%0d", tag, k), ack, 1);
         if (!w) chk($sformatf("%s_dat%0d", tag, k), dat_r, exp_arr[k]);
         @(posedge clk); #1;
      end
      chk({tag, "_ackoff"}, ack, 0);
      bus_idle();
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ack", ack, 0);
      chk("post_rst_err", err, 0);

      // Classic write/read round trip
      classic(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0, "wr_beef");
      classic(32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1, "rd_beef");

      // Byte lanes: sel=0101 over all-ones
      classic(32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b0, "wr_ones");
      classic(32'h0000_0014, 32'h1122_3344, 4'h5, 1'b1, 32'h0, 1'b0, "wr_lane");
      classic(32'h0000_0014, 32'h0,         4'hF, 1'b0, 32'hFF22_FF44, 1'b1, "rd_lane");

      // sel=0 write is acked but changes nothing
      classic(32'h0000_0014, 32'h0000_0000, 4'h0, 1'b1, 32'h0, 1'b0, "wr_sel0");
      classic(32'h0000_0014, 32'h0,         4'hF, 1'b0, 32'hFF22_FF44, 1'b1, "rd_sel0");

      // Out of range: error only, no write (0x0002_0010 would alias word 4)
      oor_access(32'h0002_0000, 1'b0, "oor_rd");
      oor_access(32'h0002_0010, 1'b1, "oor_wr");
      classic(32'h0000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1, "rd_after_oor");

      // Bank boundary and top word
      classic(32'h0000_1FFC, 32'h07FF_07FF, 4'hF, 1'b1, 32'h0, 1'b0, "wr_7ff");
      classic(32'h0000_2000, 32'h0800_0800, 4'hF, 1'b1, 32'h0, 1'b0, "wr_800");
      classic(32'h0000_7FFC, 32'h1FFF_1FFF, 4'hF, 1'b1, 32'h0, 1'b0, "wr_top");
      classic(32'h0000_1FFC, 32'h0, 4'hF, 1'b0, 32'h07FF_07FF, 1'b1, "rd_7ff");
      classic(32'h0000_2000, 32'h0, 4'hF, 1'b0, 32'h0800_0800, 1'b1, "rd_800");
      classic(32'h0000_7FFC, 32'h0, 4'hF, 1'b0, 32'h1FFF_1FFF, 1'b1, "rd_top");

      // cyc dropped during the ack cycle: no write
      classic(32'h0000_0024, 32'h1234_5678, 4'hF, 1'b1, 32'h0, 1'b0, "wr_w9");
      cyc = 1'b1; stb = 1'b1; adr = 32'h0000_0024; dat_w = 32'hBAD0_BAD0; sel = 4'hF; we = 1'b1;
      @(posedge clk); #1;
      chk("abort_ack", ack, 1);
      bus_idle();
      @(posedge clk); #1;
      chk("abort_ackoff", ack, 0);
      classic(32'h0000_0024, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 1'b1, "rd_abort");

      // Reset across a classic write's completing edge discards it
      cyc = 1'b1; stb = 1'b1; adr = 32'h0000_0024; dat_w = 32'hCAFE_CAFE; sel = 4'hF; we = 1'b1;
      @(posedge clk); #1;
      chk("rstwr_ack", ack, 1);
      #3 rst = 1'b1;
      #1 chk("rstwr_ackdrop", ack, 0);
      @(posedge clk); #1;
      bus_idle();
      rst = 1'b0;
      @(posedge clk); #1;
      classic(32'h0000_0024, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 1'b1, "rd_rstwr");

`ifdef MINSOC_RAM_BURST_EN
      // Prefill words 0x7FE..0x801, 0x1FFF and 0
      classic(32'h0000_1FF8, 32'h0B00_07FE, 4'hF, 1'b1, 32'h0, 1'b0, "pf0");
      classic(32'h0000_1FFC, 32'h0B00_07FF, 4'hF, 1'b1, 32'h0, 1'b0, "pf1");
      classic(32'h0000_2000, 32'h0B00_0800, 4'hF, 1'b1, 32'h0, 1'b0, "pf2");
      classic(32'h0000_2004, 32'h0B00_0801, 4'hF, 1'b1, 32'h0, 1'b0, "pf3");
      classic(32'h0000_7FFC, 32'h0B00_1FFF, 4'hF, 1'b1, 32'h0, 1'b0, "pf4");
      classic(32'h0000_0000, 32'h0B00_0000, 4'hF, 1'b1, 32'h0, 1'b0, "pf5");

      // Linear 4-beat read crossing the bank boundary
      exp_arr[0] = 32'h0B00_07FE; exp_arr[1] = 32'h0B00_07FF;
      exp_arr[2] = 32'h0B00_0800; exp_arr[3] = 32'h0B00_0801;
      for (int k = 0; k < 16; k++) wd_arr[k] = 32'h0;
      burst(32'h0000_1FF8, 1'b0, 2'b00, 4, "lin_rd");

      // Linear read wrapping from the top word to word 0
      exp_arr[0] = 32'h0B00_1FFF; exp_arr[1] = 32'h0B00_0000;
      burst(32'h0000_7FFC, 1'b0, 2'b00, 2, "lin_top");

      // Wrap-4 write from word 6: 6,7,4,5 <- A0..A3
      for (int k = 0; k < 4; k++) wd_arr[k] = 32'hA0 + k;
      burst(32'h0000_0018, 1'b1, 2'b01, 4, "wrap4_wr");
      classic(32'h0000_0010, 32'h0, 4'hF, 1'b0, 32'h0000_00A2, 1'b1, "wrap_w4");
      classic(32'h0000_0014, 32'h0, 4'hF, 1'b0, 32'h0000_00A3, 1'b1, "wrap_w5");
      classic(32'h0000_0018, 32'h0, 4'hF, 1'b0, 32'h0000_00A0, 1'b1, "wrap_w6");
      classic(32'h0000_001C, 32'h0, 4'hF, 1'b0, 32'h0000_00A1, 1'b1, "wrap_w7");

      // Reset during beat 2 of an 8-beat linear write from word 0x20
      for (int k = 0; k < 8; k++)
         classic(32'h0000_0080 + 32'(4 * k), 32'h5555_5555, 4'hF, 1'b1, 32'h0, 1'b0, "pf_rst");
      cyc = 1'b1; stb = 1'b1; adr = 32'h0000_0080; we = 1'b1; bte = 2'b00; cti = 3'b010;
      sel = 4'hF; dat_w = 32'hC0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         dat_w = 32'hC0 + k;
         adr   = 32'h0000_0FF0;
         chk($sformatf("rstb_ack%0d", k), ack, 1);
         @(posedge clk); #1;
      end
      dat_w = 32'hC2;
      chk("rstb_ack2", ack, 1);
      #3 rst = 1'b1;
      #1 chk("rstb_ackdrop", ack, 0);
      @(posedge clk); #1;
      bus_idle();
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rstb_idle", ack, 0);
      classic(32'h0000_0080, 32'h0, 4'hF, 1'b0, 32'h0000_00C0, 1'b1, "rstb_w0");
      classic(32'h0000_0084, 32'h0, 4'hF, 1'b0, 32'h0000_00C1, 1'b1, "rstb_w1");
      for (int k = 2; k < 8; k++)
         classic(32'h0000_0080 + 32'(4 * k), 32'h0, 4'hF, 1'b0, 32'h5555_5555, 1'b1,
                 $sformatf("rstb_w%0d", k));
`else
      // Without burst support an incrementing-burst request is a plain classic access
      cyc = 1'b1; stb = 1'b1; adr = 32'h0000_0010; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
      @(posedge clk); #1;
      chk("nob_ack", ack, 1);
      chk("nob_dat", dat_r, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("nob_ackoff", ack, 0);
      bus_idle();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("nob_idle", ack, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
